unioperand_mc_ctrl: RTL and testbench
=====================================

Name: unioperand_mc_ctrl

Overview:
- Multi-cycle control unit for the 16-bit unioperand (accumulator) processor.
- Sequences fetch/decode/memory/execute for the 5-bit-PC datapath and drives the 8-bit control word, ALU op select and jump strobe.
- Handshakes with a data memory that may take several cycles (dm_ready), bounded by a timeout.
- Sits beside the datapath inside top1 and replaces the single-cycle combinational decoder.

Parameters:
- WAIT_MAX, 15: max cycles in MEM with dm_ready low before timeout fault (1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- opcode_in  input  4  im_out[15:12] of the instruction currently at PC
- zf  input  1  accumulator zero flag from datapath
- dm_ready  input  1  data memory access complete this cycle
- cw  output  8  {pc_inc, pc_ld, ir_ld, acc_ld, acc_src, dm_req, dm_we, halted}
- alu_op  output  3  000 passB, 001 add, 010 sub, 011 and, 100 or, 101 xor
- j  output  1  equals cw[6] (pc_ld)
- state  output  3  current FSM state
- fault  output  2  00 none, 01 illegal opcode, 10 memory timeout; sticky
- retired  output  CNT_W  retired-instruction count, saturating

Behaviour:
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 LDI, 9 JMP, A JZ, B JNZ, F HLT. C/D/E are illegal.
- States: FETCH=0, DECODE=1, MEM=2, EXEC=3, HALT=4. Encodings 5-7 recover to HALT with fault=01.
- Reset (rst=0, async): state=FETCH, latched opcode=NOP, wait counter=0, fault=00, retired=0. All outputs are forced to 0 while rst=0, including cw, alu_op and j.
- FETCH: assert ir_ld=1 and pc_inc=1; latch opcode_in into an internal opcode register. Next state DECODE. Always exactly 1 cycle.
- DECODE, using the latched opcode:
  - NOP: retire, go to FETCH.
  - JMP: pc_ld=1, retire, go to FETCH.
  - JZ: pc_ld=zf, combinational from zf in this cycle; retire, go to FETCH.
  - JNZ: pc_ld=~zf; retire, go to FETCH.
  - LDI: acc_ld=1, acc_src=1 (immediate); retire, go to FETCH.
  - LDA/STA/ADD/SUB/AND/OR/XOR: go to MEM, clear wait counter.
  - HLT: go to HALT, retire.
  - Illegal: go to HALT, fault=01, no retire.
- MEM: dm_req=1; dm_we=1 only for STA.
  - dm_ready=1: STA retires and goes to FETCH; all others go to EXEC.
  - dm_ready=0: increment the wait counter. When the counter equals WAIT_MAX-1 and dm_ready is still 0, go to HALT with fault=10 and no retire.
  - dm_ready is sampled only in MEM.
- EXEC: acc_ld=1, acc_src=0. alu_op: LDA passB, ADD add, SUB sub, AND and, OR or, XOR xor. Retire, go to FETCH.
- alu_op is 000 in every state other than EXEC.
- HALT: halted=1, all other cw bits 0. Terminal; only rst exits.
- fault: a non-zero value is never overwritten by a later fault.
- retired: +1 on each retire event; saturates at all-ones.
- Latency: jumps/LDI/NOP 2 cycles; LDA/ALU ops 3+N; STA 2+N. N = cycles until dm_ready, minimum 1.
- Reset mid-MEM: dm_req drops immediately (asynchronous); no write is issued after rst deasserts.

Decomposition:
- Package unioperand_pkg holds:
  - opcode constants,
  - state encodings,
  - alu_op codes,
  - cw bit index constants.
- The datapath and the bench import it.
- One sub-module, unioperand_decode: pure combinational (state, opcode, zf) -> cw/alu_op/next-state class. The FSM registers, wait counter, fault and retired counter stay in unioperand_mc_ctrl.

Test Plan:
- Reset then NOP stream: cw=8'hA0 in FETCH, 0 in DECODE; 2-cycle cadence; retired=3 after 6 cycles.
- ADD with dm_ready low 2 cycles then high: state FETCH->DECODE->MEM(x3)->EXEC; alu_op=001 and acc_ld=1 in EXEC only; retired+1.
- STA, dm_ready=1 in first MEM cycle: dm_req=dm_we=1 for exactly 1 cycle; no EXEC; next state FETCH.
- JZ with zf=1 then JZ with zf=0: j=1 in the first DECODE only; JNZ with zf=0 gives j=1.
- LDA with dm_ready held 0 and WAIT_MAX=4: HALT after 4 MEM cycles; fault=10, cw=8'h01, retired unchanged.
- Opcode D: HALT, fault=01. Then rst pulse low mid-HALT: all outputs 0 while low; FETCH resumes with fault=00.

Source files
------------

// File: rtl/unioperand_pkg.sv
// Shared encodings for the unioperand accumulator processor: opcodes, FSM states,
// ALU select codes and control-word bit positions.
package unioperand_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CW_W  = 8;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_STA = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_AND = 4'h5;
  localparam logic [OP_W-1:0] OP_OR  = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR = 4'h7;
  localparam logic [OP_W-1:0] OP_LDI = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP = 4'h9;
  localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
  localparam logic [OP_W-1:0] OP_JNZ = 4'hB;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [ALU_W-1:0] ALU_PASSB = 3'b000;
  localparam logic [ALU_W-1:0] ALU_ADD   = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB   = 3'b010;
  localparam logic [ALU_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALU_W-1:0] ALU_XOR   = 3'b101;

  localparam int unsigned CW_PC_INC  = 7;
  localparam int unsigned CW_PC_LD   = 6;
  localparam int unsigned CW_IR_LD   = 5;
  localparam int unsigned CW_ACC_LD  = 4;
  localparam int unsigned CW_ACC_SRC = 3;
  localparam int unsigned CW_DM_REQ  = 2;
  localparam int unsigned CW_DM_WE   = 1;
  localparam int unsigned CW_HALTED  = 0;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  // Next-state class produced by the decoder; MEM resolution needs dm_ready and the wait counter.
  typedef enum logic [2:0] {
    NC_DECODE    = 3'd0,
    NC_RETIRE    = 3'd1,
    NC_MEM_ENTER = 3'd2,
    NC_MEM_WAIT  = 3'd3,
    NC_HALT_RET  = 3'd4,
    NC_HALT_ILL  = 3'd5,
    NC_HALT_STAY = 3'd6
  } nxt_class_t;

endpackage

// File: rtl/unioperand_decode.sv
// Combinational control decoder: (state, latched opcode, zf) -> control word,
// ALU select and next-state class.
module unioperand_decode
  import unioperand_pkg::*;
(
  input  state_t             state,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zf,
  output logic [CW_W-1:0]    cw,
  output logic [ALU_W-1:0]   alu_op,
  output nxt_class_t         nc
);

  always_comb begin
    cw     = '0;
    alu_op = ALU_PASSB;
    nc     = NC_HALT_ILL;
    case (state)
      S_FETCH: begin
        cw[CW_PC_INC] = 1'b1;
        cw[CW_IR_LD]  = 1'b1;
        nc            = NC_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: nc = NC_RETIRE;
          OP_JMP: begin
            cw[CW_PC_LD] = 1'b1;
            nc           = NC_RETIRE;
          end
          OP_JZ: begin
            cw[CW_PC_LD] = zf;
            nc           = NC_RETIRE;
          end
          OP_JNZ: begin
            cw[CW_PC_LD] = ~zf;
            nc           = NC_RETIRE;
          end
          OP_LDI: begin
            cw[CW_ACC_LD]  = 1'b1;
            cw[CW_ACC_SRC] = 1'b1;
            nc             = NC_RETIRE;
          end
          OP_LDA, OP_STA, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR: nc = NC_MEM_ENTER;
          OP_HLT: nc = NC_HALT_RET;
          default: nc = NC_HALT_ILL;
        endcase
      end
      S_MEM: begin
        cw[CW_DM_REQ] = 1'b1;
        cw[CW_DM_WE]  = (opcode == OP_STA);
        nc            = NC_MEM_WAIT;
      end
      S_EXEC: begin
        cw[CW_ACC_LD] = 1'b1;
        nc            = NC_RETIRE;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          OP_OR:   alu_op = ALU_OR;
          OP_XOR:  alu_op = ALU_XOR;
          default: alu_op = ALU_PASSB;
        endcase
      end
      S_HALT: begin
        cw[CW_HALTED] = 1'b1;
        nc            = NC_HALT_STAY;
      end
      default: nc = NC_HALT_ILL;
    endcase
  end

endmodule

// File: rtl/unioperand_mc_ctrl.sv
// Multi-cycle control unit for the unioperand processor: FSM, memory wait
// timeout, sticky fault code and saturating retired-instruction counter.
module unioperand_mc_ctrl
  import unioperand_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode_in,
  input  logic              zf,
  input  logic              dm_ready,
  output logic [7:0]        cw,
  output logic [2:0]        alu_op,
  output logic              j,
  output logic [2:0]        state,
  output logic [1:0]        fault,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned WAIT_W = 8;

  state_t            state_q;
  logic [OP_W-1:0]   opcode_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CW_W-1:0]   cw_dec;
  logic [ALU_W-1:0]  alu_dec;
  nxt_class_t        nc;
  logic              retire;
  logic              timeout;

  unioperand_decode u_decode (
    .state  (state_q),
    .opcode (opcode_q),
    .zf     (zf),
    .cw     (cw_dec),
    .alu_op (alu_dec),
    .nc     (nc)
  );

  // Reset gates the decoded strobes so dm_req/pc_ld drop the moment rst falls.
  assign cw     = rst ? cw_dec  : '0;
  assign alu_op = rst ? alu_dec : '0;
  assign j      = cw[CW_PC_LD];
  assign state  = state_q;

  assign timeout = !dm_ready && (wait_q == WAIT_W'(WAIT_MAX - 1));

  always_comb begin
    retire = 1'b0;
    case (nc)
      NC_RETIRE, NC_HALT_RET: retire = 1'b1;
      NC_MEM_WAIT:            retire = dm_ready && (opcode_q == OP_STA);
      default:                retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      opcode_q <= OP_NOP;
      wait_q   <= '0;
      fault    <= FLT_NONE;
      retired  <= '0;
    end else begin
      if (retire && (retired != '1))
        retired <= retired + CNT_W'(1);
      case (nc)
        NC_DECODE: begin
          state_q  <= S_DECODE;
          opcode_q <= opcode_in;
        end
        NC_RETIRE: state_q <= S_FETCH;
        NC_MEM_ENTER: begin
          state_q <= S_MEM;
          wait_q  <= '0;
        end
        NC_MEM_WAIT: begin
          if (dm_ready) begin
            state_q <= (opcode_q == OP_STA) ? S_FETCH : S_EXEC;
          end else if (timeout) begin
            state_q <= S_HALT;
            if (fault == FLT_NONE)
              fault <= FLT_TIMEOUT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        NC_HALT_RET: state_q <= S_HALT;
        NC_HALT_ILL: begin
          state_q <= S_HALT;
          if (fault == FLT_NONE)
            fault <= FLT_ILLEGAL;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_unioperand_mc_ctrl.sv
// Directed self-checking bench for unioperand_mc_ctrl (WAIT_MAX=4).
module tb_unioperand_mc_ctrl;
  import unioperand_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode_in;
  logic        zf;
  logic        dm_ready;
  logic [7:0]  cw;
  logic [2:0]  alu_op;
  logic        j;
  logic [2:0]  state;
  logic [1:0]  fault;
  logic [15:0] retired;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_ret = 0;

  unioperand_mc_ctrl #(.WAIT_MAX(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode_in (opcode_in),
    .zf        (zf),
    .dm_ready  (dm_ready),
    .cw        (cw),
    .alu_op    (alu_op),
    .j         (j),
    .state     (state),
    .fault     (fault),
    .retired   (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present an opcode in FETCH, confirm the fetch strobes and advance to DECODE.
  task automatic do_fetch(input logic [3:0] op);
    opcode_in = op;
    #1;
    check("fetch_state", 32'(state), 32'(S_FETCH));
    check("fetch_cw", 32'(cw), 32'hA0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cw"}, 32'(cw), 32'h00);
    check({tag, "_alu"}, 32'(alu_op), 32'h0);
    check({tag, "_j"}, 32'(j), 32'h0);
    check({tag, "_state"}, 32'(state), 32'h0);
    check({tag, "_fault"}, 32'(fault), 32'h0);
    check({tag, "_ret"}, 32'(retired), 32'h0);
  endtask

  initial begin
    rst = 1'b0; opcode_in = OP_NOP; zf = 1'b0; dm_ready = 1'b0;
    #12;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_state", 32'(state), 32'(S_FETCH));
    check("rel_cw", 32'(cw), 32'hA0);

    // NOP stream: 2-cycle cadence, three retires in six cycles
    tick();
    #1;
    check("nop_dec_state", 32'(state), 32'(S_DECODE));
    check("nop_dec_cw", 32'(cw), 32'h00);
    for (int i = 0; i < 5; i++) tick();
    exp_ret = 3;
    #1;
    check("nop_state", 32'(state), 32'(S_FETCH));
    check("nop_retired", 32'(retired), 32'(exp_ret));

    // ADD with two wait cycles
    do_fetch(OP_ADD);
    #1;
    check("add_dec_state", 32'(state), 32'(S_DECODE));
    check("add_dec_alu", 32'(alu_op), 32'(ALU_PASSB));
    tick();
    #1;
    check("add_mem1_state", 32'(state), 32'(S_MEM));
    check("add_mem1_cw", 32'(cw), 32'h04);
    tick();
    tick();
    dm_ready = 1'b1;
    #1;
    check("add_mem3_state", 32'(state), 32'(S_MEM));
    tick();
    dm_ready = 1'b0;
    #1;
    check("add_exec_state", 32'(state), 32'(S_EXEC));
    check("add_exec_cw", 32'(cw), 32'h10);
    check("add_exec_alu", 32'(alu_op), 32'(ALU_ADD));
    check("add_exec_ret", 32'(retired), 32'(exp_ret));
    tick();
    exp_ret++;
    #1;
    check("add_done_state", 32'(state), 32'(S_FETCH));
    check("add_done_alu", 32'(alu_op), 32'h0);
    check("add_done_ret", 32'(retired), 32'(exp_ret));

    // STA completing in the first MEM cycle
    do_fetch(OP_STA);
    tick();
    dm_ready = 1'b1;
    #1;
    check("sta_mem_cw", 32'(cw), 32'h06);
    tick();
    dm_ready = 1'b0;
    exp_ret++;
    #1;
    check("sta_next_state", 32'(state), 32'(S_FETCH));
    check("sta_next_cw", 32'(cw), 32'hA0);
    check("sta_ret", 32'(retired), 32'(exp_ret));

    // Conditional jumps, JMP and LDI
    zf = 1'b1;
    do_fetch(OP_JZ);
    #1;
    check("jz1_j", 32'(j), 32'h1);
    check("jz1_cw", 32'(cw), 32'h40);
    tick();
    exp_ret++;
    zf = 1'b0;
    do_fetch(OP_JZ);
    #1;
    check("jz0_j", 32'(j), 32'h0);
    check("jz0_cw", 32'(cw), 32'h00);
    tick();
    exp_ret++;
    do_fetch(OP_JNZ);
    #1;
    check("jnz0_j", 32'(j), 32'h1);
    tick();
    exp_ret++;
    do_fetch(OP_JMP);
    #1;
    check("jmp_cw", 32'(cw), 32'h40);
    tick();
    exp_ret++;
    do_fetch(OP_LDI);
    #1;
    check("ldi_cw", 32'(cw), 32'h18);
    tick();
    exp_ret++;
    #1;
    check("jumps_ret", 32'(retired), 32'(exp_ret));

    // Reset while a store is in MEM
    do_fetch(OP_STA);
    tick();
    #1;
    check("sta_rst_pre_cw", 32'(cw), 32'h06);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mem");
    @(negedge clk);
    rst = 1'b1;
    exp_ret = 0;
    #1;
    check("rst_mem_rel_state", 32'(state), 32'(S_FETCH));
    check("rst_mem_rel_cw", 32'(cw), 32'hA0);

    // LDA timeout after 4 MEM cycles
    do_fetch(OP_LDA);
    tick();
    #1;
    check("lda_mem1_state", 32'(state), 32'(S_MEM));
    tick();
    tick();
    tick();
    #1;
    check("lda_mem4_state", 32'(state), 32'(S_MEM));
    tick();
    #1;
    check("to_state", 32'(state), 32'(S_HALT));
    check("to_fault", 32'(fault), 32'(FLT_TIMEOUT));
    check("to_cw", 32'(cw), 32'h01);
    check("to_ret", 32'(retired), 32'(exp_ret));
    dm_ready = 1'b1;
    tick();
    dm_ready = 1'b0;
    #1;
    check("to_stay_state", 32'(state), 32'(S_HALT));
    check("to_stay_fault", 32'(fault), 32'(FLT_TIMEOUT));

    rst = 1'b0;
    #1;
    check_reset_outputs("rst_to");
    @(negedge clk);
    rst = 1'b1;

    // Illegal opcode D
    do_fetch(4'hD);
    #1;
    check("ill_dec_cw", 32'(cw), 32'h00);
    tick();
    #1;
    check("ill_state", 32'(state), 32'(S_HALT));
    check("ill_fault", 32'(fault), 32'(FLT_ILLEGAL));
    check("ill_cw", 32'(cw), 32'h01);
    check("ill_ret", 32'(retired), 32'h0);
    tick();

    // Reset pulse mid-HALT
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_halt");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_halt_rel_state", 32'(state), 32'(S_FETCH));
    check("rst_halt_rel_cw", 32'(cw), 32'hA0);
    check("rst_halt_rel_fault", 32'(fault), 32'h0);

    // HLT retires and halts cleanly
    do_fetch(OP_HLT);
    tick();
    #1;
    check("hlt_state", 32'(state), 32'(S_HALT));
    check("hlt_ret", 32'(retired), 32'h1);
    check("hlt_fault", 32'(fault), 32'h0);
    check("hlt_cw", 32'(cw), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
